// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage between the program ROM and the decoder.
// It holds the program counter and drives the ROM address straight from it.
// The returned word is registered into a one-entry output slot.
// The slot is handed to the decoder with a valid/ready handshake.
// Jumps redirect the PC and discard any unaccepted instruction.
// Fetching stops after the halt word is captured, until a jump or reset.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   rst          synchronous active-high reset
//   rom_addr     ROM address, combinationally equal to PC
//   rom_data     ROM word for rom_addr (same-cycle read)
//   instr        registered instruction presented to the decoder
//   instr_pc     address instr was fetched from
//   instr_valid  instr/instr_pc hold an unconsumed instruction
//   instr_ready  decoder accepts instr this cycle
//   jump_en      single-cycle redirect request
//   jump_addr    redirect target, sampled when jump_en=1
//   halted       fetch stopped by the halt word

module fetch_unit #(
    parameter int             M         = 8,
    parameter int             N         = 9,
    parameter logic [M-1:0]   RESET_PC  = '0,
    parameter logic [N-1:0]   HALT_WORD = '1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [M-1:0] rom_addr,
    input  logic [N-1:0] rom_data,
    output logic [N-1:0] instr,
    output logic [M-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         jump_en,
    input  logic [M-1:0] jump_addr,
    output logic         halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    localparam logic [M-1:0] PC_ONE = {{(M-1){1'b0}}, 1'b1};

    state_t       state, state_n;
    logic [M-1:0] pc, pc_n;
    logic [N-1:0] instr_n;
    logic [M-1:0] instr_pc_n;
    logic         valid_n;
    logic         slot_free;

    // The slot can take a new word when it is empty or being drained this cycle.
    assign slot_free = !instr_valid || instr_ready;
    assign rom_addr  = pc;

    // halted is simply the HALT state.
    // It rises on the capturing edge and clears on jump or reset.
    assign halted    = (state == HALT);

    // Next-state logic.
    // A jump takes priority over everything except reset and never captures.
    // Without a jump, FETCH captures whenever the slot is free.
    // HALT only lets the last word drain.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        valid_n    = instr_valid;

        if (jump_en) begin
            pc_n    = jump_addr;
            valid_n = 1'b0;
            state_n = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (slot_free) begin
                        instr_n    = rom_data;
                        instr_pc_n = pc;
                        valid_n    = 1'b1;
                        pc_n       = pc + PC_ONE;
                        if (rom_data == HALT_WORD) begin
                            state_n = HALT;
                        end
                    end
                end
                HALT: begin
                    if (instr_valid && instr_ready) begin
                        valid_n = 1'b0;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // State register; reset overrides jumps, stalls and the halt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Table-driven bench for fetch_unit.
// It uses a behavioural 256x9 ROM with mem[i]=i.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are checked in the same place, once the edge has settled.
// Hand-written sequences cover halt, restart by jump, and reset while halted.

module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic [7:0] rom_addr;
    logic [8:0] rom_data;
    logic [8:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       halted;

    logic [8:0] mem [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       jump_en;
        logic [7:0] jump_addr;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_pc;
        logic [8:0] exp_instr;
        logic [7:0] exp_rom;
        logic       exp_halted;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(
        .M(8), .N(9), .RESET_PC(8'h00), .HALT_WORD(9'h1FF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .halted     (halted)
    );

    // Combinational ROM model.
    assign rom_data = mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic je, input logic [7:0] ja, input logic rdy);
        rst         = r;
        jump_en     = je;
        jump_addr   = ja;
        instr_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic v, input logic [7:0] p,
                            input logic [8:0] i, input logic [7:0] ra, input logic h);
        checkOutput({tag, ".valid"},    32'(instr_valid), 32'(v));
        checkOutput({tag, ".instr_pc"}, 32'(instr_pc),    32'(p));
        checkOutput({tag, ".instr"},    32'(instr),       32'(i));
        checkOutput({tag, ".rom_addr"}, 32'(rom_addr),    32'(ra));
        checkOutput({tag, ".halted"},   32'(halted),      32'(h));
    endtask

    // Adds one vector; the expected instruction follows from mem[i]=i.
    task automatic addVec(input logic r, input logic je, input logic [7:0] ja, input logic rdy,
                          input logic v, input logic [7:0] p, input logic [7:0] ra);
        vec_t t;
        t.rst = r; t.jump_en = je; t.jump_addr = ja; t.ready = rdy;
        t.exp_valid = v; t.exp_pc = p; t.exp_instr = {1'b0, p};
        t.exp_rom = ra; t.exp_halted = 1'b0;
        vecs.push_back(t);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'(i);
        rst = 1'b1; jump_en = 1'b0; jump_addr = 8'h00; instr_ready = 1'b0;

        //      rst je  addr   rdy  valid pc     rom
        addVec(1, 0, 8'h00, 0,   0, 8'h00, 8'h00);   // reset
        addVec(0, 0, 8'h00, 1,   1, 8'h00, 8'h01);   // first capture
        addVec(0, 0, 8'h00, 1,   1, 8'h01, 8'h02);
        addVec(0, 0, 8'h00, 1,   1, 8'h02, 8'h03);
        addVec(0, 0, 8'h00, 1,   1, 8'h03, 8'h04);
        addVec(0, 1, 8'hFE, 1,   0, 8'h03, 8'hFE);   // jump to FE: bubble
        addVec(0, 0, 8'h00, 1,   1, 8'hFE, 8'hFF);
        addVec(0, 0, 8'h00, 1,   1, 8'hFF, 8'h00);   // wrap
        addVec(0, 0, 8'h00, 1,   1, 8'h00, 8'h01);
        addVec(0, 0, 8'h00, 1,   1, 8'h01, 8'h02);
        addVec(0, 1, 8'h0F, 1,   0, 8'h01, 8'h0F);
        addVec(0, 0, 8'h00, 1,   1, 8'h0F, 8'h10);
        addVec(0, 0, 8'h00, 1,   1, 8'h10, 8'h11);
        for (int k = 0; k < 5; k++)
            addVec(0, 0, 8'h00, 0, 1, 8'h10, 8'h11); // 5-cycle stall
        addVec(0, 0, 8'h00, 1,   1, 8'h11, 8'h12);   // release, no bubble
        addVec(0, 1, 8'h20, 1,   0, 8'h11, 8'h20);
        addVec(0, 0, 8'h00, 1,   1, 8'h20, 8'h21);
        addVec(0, 0, 8'h00, 0,   1, 8'h20, 8'h21);   // stalled at 20
        addVec(0, 1, 8'h80, 0,   0, 8'h20, 8'h80);   // jump during stall
        addVec(0, 0, 8'h00, 1,   1, 8'h80, 8'h81);
        addVec(0, 0, 8'h00, 0,   1, 8'h80, 8'h81);   // stall
        addVec(1, 1, 8'h40, 0,   0, 8'h00, 8'h00);   // reset mid-stall beats jump
        addVec(0, 0, 8'h00, 1,   1, 8'h00, 8'h01);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].rst, vecs[n].jump_en, vecs[n].jump_addr, vecs[n].ready);
            checkAll($sformatf("vec%0d", n), vecs[n].exp_valid, vecs[n].exp_pc,
                     vecs[n].exp_instr, vecs[n].exp_rom, vecs[n].exp_halted);
        end

        // Halt sequence: mem[5] holds the halt word.
        mem[5] = 9'h1FF;
        applyStimulus(1, 0, 8'h00, 1);
        checkAll("halt.reset", 0, 8'h00, 9'h000, 8'h00, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 8'h00, 1);
            checkAll($sformatf("halt.w%0d", k), 1, 8'(k), 9'(k), 8'(k + 1), 0);
        end
        applyStimulus(0, 0, 8'h00, 1);
        checkAll("halt.capture", 1, 8'h05, 9'h1FF, 8'h06, 1);
        applyStimulus(0, 0, 8'h00, 1);
        checkAll("halt.drain", 0, 8'h05, 9'h1FF, 8'h06, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 8'h00, 1);
            checkAll($sformatf("halt.idle%0d", k), 0, 8'h05, 9'h1FF, 8'h06, 1);
        end
        applyStimulus(0, 1, 8'h00, 1);
        checkAll("halt.jump", 0, 8'h05, 9'h1FF, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkAll("halt.refetch", 1, 8'h00, 9'h000, 8'h01, 0);

        // Run into the halt again, then reset while halted and stalled.
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 0);
        checkAll("halt2.capture", 1, 8'h05, 9'h1FF, 8'h06, 1);
        applyStimulus(1, 0, 8'h00, 0);
        checkAll("halt2.reset", 0, 8'h00, 9'h000, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkAll("halt2.resume", 1, 8'h00, 9'h000, 8'h01, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
